// File: rtl/jump_redirect_unit_pkg.sv
// Shared definitions for the jump-target path: FSM encoding, link register
// number, J-format field width and the jump target formation rule.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } jr_state_e;

    localparam logic [4:0] LINK_REG  = 5'd31;
    localparam int         J_INDEX_W = 26;

    // Target = PC region bits, instruction index, word alignment. The index is
    // concatenated, never added, so it can never carry into the region bits.
    function automatic logic [31:0] form_jump_target(
        input logic [31:0]          pc_plus4,
        input logic [J_INDEX_W-1:0] index
    );
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/jump_redirect_unit_if.sv
// Redirect handshake between the jump unit (master) and the PC unit (slave).
interface jump_redirect_unit_if #(
    parameter int ADDR_W = 32
);
    logic              RedirectValid;
    logic [ADDR_W-1:0] RedirectTarget;
    logic              RedirectReady;

    modport master (
        output RedirectValid,
        output RedirectTarget,
        input  RedirectReady
    );

    modport slave (
        input  RedirectValid,
        input  RedirectTarget,
        output RedirectReady
    );
endinterface

// File: rtl/jump_redirect_unit.sv
// Jump redirect unit: forms the J/JAL target, offers it to the PC unit over a
// valid/ready handshake, stalls ID while waiting, flushes IF/ID afterwards and
// pulses the JAL link write on acceptance.
// Optional build macro JUMP_REDIRECT_STATS_EN adds saturating JumpCount and
// StallCycles statistics outputs.
module jump_redirect_unit
    import datapath_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 JumpValid,
    input  logic                 IsLink,
    input  logic [J_INDEX_W-1:0] InstrIndex,
    input  logic [ADDR_W-1:0]    PCPlus4,
    input  logic                 Kill,
    jump_redirect_unit_if.master redir,
    output logic                 StallID,
    output logic                 FlushIFID,
    output logic                 LinkValid,
    output logic [ADDR_W-1:0]    LinkAddr
`ifdef JUMP_REDIRECT_STATS_EN
    ,
    output logic [CNT_W-1:0]     JumpCount,
    output logic [CNT_W-1:0]     StallCycles
`endif
);

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    jr_state_e         state_q, state_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic              link_flag_q, link_flag_d;
    logic              accept;

    // Handshake completes only in REQ; Kill overrides a simultaneous ready.
    assign accept = (state_q == REQ) && redir.RedirectReady && !Kill;

    // Next-state and captured-datapath logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        target_d    = target_q;
        link_addr_d = link_addr_q;
        link_flag_d = link_flag_q;

        if (Kill) begin
            state_d     = IDLE;
            flush_cnt_d = 2'd0;
            link_flag_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (JumpValid) begin
                        state_d     = REQ;
                        target_d    = form_jump_target(PCPlus4, InstrIndex);
                        link_flag_d = IsLink;
                        link_addr_d = PCPlus4;
                    end
                end
                REQ: begin
                    if (redir.RedirectReady) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LAST;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    flush_cnt_d = 2'd0;
                end
            endcase
        end
    end

    // State, counter and captured target/link registers.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: the target and link address are datapath registers but are
        // still reset, because they are visible outputs that must read 0.
        if (Reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= 2'd0;
            target_q    <= '0;
            link_addr_q <= '0;
            link_flag_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            target_q    <= target_d;
            link_addr_q <= link_addr_d;
            link_flag_q <= link_flag_d;
        end
    end

    // Outputs decode directly from the state register.
    always_comb begin
        redir.RedirectValid  = (state_q == REQ) && !Kill;
        redir.RedirectTarget = target_q;
        StallID              = (state_q == REQ);
        FlushIFID            = (state_q == FLUSH);
        LinkValid            = accept && link_flag_q;
        LinkAddr             = link_addr_q;
    end

`ifdef JUMP_REDIRECT_STATS_EN
    logic [CNT_W-1:0] jump_count_q, jump_count_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    // Saturating statistics: accepted redirects and REQ cycles without ready.
    always_comb begin
        jump_count_d   = jump_count_q;
        stall_cycles_d = stall_cycles_q;
        if (accept && (jump_count_q != '1)) begin
            jump_count_d = jump_count_q + 1'b1;
        end
        if ((state_q == REQ) && !redir.RedirectReady && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            jump_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            jump_count_q   <= jump_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign JumpCount   = jump_count_q;
    assign StallCycles = stall_cycles_q;
`endif

endmodule

// File: doc/jump_redirect_unit.md
Name: jump_redirect_unit

Overview:
- Consumer end of the jump-target path: takes the 26-bit J-format instruction index from ID and forms the 32-bit byte target {PCPlus4[31:28], index, 2'b00}.
- Registers the target and presents it to the PC unit over a valid/ready redirect handshake.
- Stalls ID until the PC unit accepts, then flushes IF/ID.
- Generates the JAL link write.

Parameters:
- ADDR_W, 32, width of PC / target / link address.
- FLUSH_CYCLES, 1, number of cycles FlushIFID is asserted after an accepted redirect (1..3).
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- JumpValid  in  1  ID holds a decoded J or JAL this cycle.
- IsLink  in  1  the instruction is JAL; qualified by JumpValid.
- InstrIndex  in  26  instruction bits [25:0].
- PCPlus4  in  ADDR_W  PC+4 of the jump instruction.
- Kill  in  1  synchronous abort (exception flush).
- RedirectReady  in  1  PC unit accepts the target this cycle.
- RedirectValid  out  1  target is valid.
- RedirectTarget  out  ADDR_W  jump target.
- StallID  out  1  hold the ID stage.
- FlushIFID  out  1  squash the IF/ID register.
- LinkValid  out  1  one-cycle pulse: write LinkAddr to $31.
- LinkAddr  out  ADDR_W  return address (PCPlus4 of the JAL).

Behaviour:
- States: IDLE, REQ, FLUSH. Encoding in package.
- Reset (async, immediate):
  - state=IDLE, flush counter=0.
  - All outputs 0, including RedirectTarget and LinkAddr.
- IDLE:
  - On JumpValid && !Kill: capture target = {PCPlus4[31:28], InstrIndex, 2'b00}; capture link flag = IsLink and LinkAddr = PCPlus4; go to REQ.
  - Latency: RedirectValid rises on the cycle after JumpValid.
  - StallID=0 in IDLE.
- REQ:
  - RedirectValid=1 and StallID=1.
  - RedirectTarget and LinkAddr stay stable until accepted.
  - On RedirectReady: go to FLUSH, and pulse LinkValid for exactly that cycle if the link flag is set.
- FLUSH:
  - RedirectValid=0, StallID=0, FlushIFID=1 for FLUSH_CYCLES cycles, counted by an internal down-counter.
  - Return to IDLE after the last flush cycle.
- Width rule: target bits [1:0] are always 00, bits [31:28] always equal PCPlus4[31:28]. No carry from the index into the region bits; index 0x3FFFFFF gives region|0x0FFFFFFC.
- Kill:
  - Any state → IDLE next cycle.
  - Suppresses the redirect and LinkValid, even if RedirectReady is high in the same cycle (Kill has priority).
  - Clears the link flag.
- JumpValid in REQ or FLUSH is ignored; upstream is stalled or squashed.
- Back-to-back jumps: a second JumpValid on the first IDLE cycle after FLUSH is accepted normally.
- RedirectReady in IDLE or FLUSH is ignored.
- Reset mid-REQ drops the redirect immediately; no LinkValid is issued.

Optional Feature:
- Macro: JUMP_REDIRECT_STATS_EN.
- Defined:
  - Adds outputs JumpCount[CNT_W-1:0] and StallCycles[CNT_W-1:0].
  - JumpCount increments on each accepted redirect.
  - StallCycles increments on each REQ cycle with RedirectReady=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (datapath_pkg):
  - state enum {IDLE, REQ, FLUSH}.
  - LINK_REG constant = 5'd31.
  - J_INDEX_W = 26.
  - Function form_jump_target(pc_plus4, index).
- No sub-module needed. The optional counters may be a small instance sat_counter (width parameter, enable, sync clear).

Test Plan:
- Basic J:
  - Stimulus: PCPlus4=0x00400004, InstrIndex=0x0100003, JumpValid one cycle, RedirectReady tied 1.
  - Required: RedirectValid high on cycle +1 with target 0x0040000C; FlushIFID high on cycle +2 for 1 cycle; LinkValid never asserts.
- JAL with backpressure:
  - Stimulus: PCPlus4=0x00400020, IsLink=1; RedirectReady low for 3 cycles.
  - Required: StallID=1 and target stable for 4 cycles; LinkValid=1 with LinkAddr=0x00400020 only on the accept cycle.
- Region bits:
  - Stimulus: PCPlus4=0xA0000010, InstrIndex=0x3FFFFFF.
  - Required: target 0xAFFFFFFC.
- Kill vs. ready:
  - Stimulus: Kill and RedirectReady asserted in the same REQ cycle.
  - Required: no FLUSH, no LinkValid, IDLE next cycle.
- Async reset during REQ:
  - Stimulus: Reset asserted mid-cycle while in REQ.
  - Required: all outputs 0 before the next edge; a jump after reset deassertion works normally.
- FLUSH_CYCLES=3 with back-to-back jumps:
  - Stimulus: two jumps back to back.
  - Required: FlushIFID high for exactly 3 cycles, JumpValid during FLUSH ignored, a new jump accepted in the first IDLE cycle.
  - With JUMP_REDIRECT_STATS_EN defined: JumpCount=2.
